// File: rtl/fetch_ctrl.sv
// Fetch-stage miss controller: PC enable, F/D flush and I-cache line refill.
// Define FETCH_CTRL_PERF_EN to add the miss and busy-cycle counters.
module fetch_ctrl #(
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32,
   localparam int IDX_W     = $clog2(LINE_WORDS),
   localparam int OFF_W     = $clog2(LINE_WORDS * 4)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] PCF,
   input  logic              icache_hit_i,
   input  logic              stall_i,
   input  logic [1:0]        PCSrcE,
   input  logic              pc_redirect_i,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   output logic              en,
   output logic              flush_d_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              refill_we_o,
   output logic [IDX_W-1:0]  refill_idx_o,
   output logic              refill_done_o,
   output logic              busy_o
`ifdef FETCH_CTRL_PERF_EN
  ,output logic [31:0]       miss_cnt_o,
   output logic [31:0]       stall_cnt_o
`endif
);

   typedef enum logic [1:0] {
      RUN,
      REQ,
      FILL,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_WORDS - 1);

   state_t            state_q;
   state_t            state_d;
   logic [IDX_W-1:0]  beat_q;
   logic [ADDR_W-1:0] addr_q;
   logic              redirect;
   logic              in_run;
   logic              miss;

   assign redirect = pc_redirect_i | (PCSrcE != 2'b00);
   assign in_run   = (state_q == RUN);
   // A redirect in the same cycle makes the missing PCF stale.
   assign miss     = in_run & ~icache_hit_i & ~redirect;

   assign en        = redirect | (in_run & icache_hit_i & ~stall_i);
   assign flush_d_o = redirect | (in_run & ~icache_hit_i & ~stall_i);
   assign busy_o    = ~in_run;

   assign mem_addr_o   = addr_q;
   assign refill_idx_o = beat_q;

   always_comb begin
      state_d       = state_q;
      mem_req_o     = 1'b0;
      refill_we_o   = 1'b0;
      refill_done_o = 1'b0;
      unique case (state_q)
         RUN: begin
            if (miss) state_d = REQ;
         end
         REQ: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) state_d = FILL;
         end
         FILL: begin
            refill_we_o = mem_rvalid_i;
            if (mem_rvalid_i && beat_q == LAST) state_d = DONE;
         end
         DONE: begin
            refill_done_o = 1'b1;
            state_d       = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Beat counter wraps to zero after the last beat of the line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         beat_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == FILL && mem_rvalid_i) beat_q <= beat_q + 1'b1;
         if (miss) addr_q <= {PCF[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         miss_cnt_o  <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (miss)   miss_cnt_o  <= miss_cnt_o + 32'd1;
         if (busy_o) stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (LINE_WORDS=4, ADDR_W=32).
// Counter scenario runs only when FETCH_CTRL_PERF_EN is defined.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PCF;
   logic        icache_hit_i;
   logic        stall_i;
   logic [1:0]  PCSrcE;
   logic        pc_redirect_i;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic        en;
   logic        flush_d_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        refill_we_o;
   logic [1:0]  refill_idx_o;
   logic        refill_done_o;
   logic        busy_o;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] miss_cnt_o;
   logic [31:0] stall_cnt_o;
`endif

   int errors = 0;
   int checks = 0;

   fetch_ctrl #(.LINE_WORDS(4), .ADDR_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .PCF           (PCF),
      .icache_hit_i  (icache_hit_i),
      .stall_i       (stall_i),
      .PCSrcE        (PCSrcE),
      .pc_redirect_i (pc_redirect_i),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .en            (en),
      .flush_d_o     (flush_d_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .refill_we_o   (refill_we_o),
      .refill_idx_o  (refill_idx_o),
      .refill_done_o (refill_done_o),
      .busy_o        (busy_o)
`ifdef FETCH_CTRL_PERF_EN
     ,.miss_cnt_o    (miss_cnt_o),
      .stall_cnt_o   (stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      icache_hit_i  = 1'b1;
      stall_i       = 1'b0;
      PCSrcE        = 2'b00;
      pc_redirect_i = 1'b0;
      mem_gnt_i     = 1'b0;
      mem_rvalid_i  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      PCF = 32'h0;
      idle();
      #2;
      checks++;
      if ({mem_req_o, refill_we_o, refill_done_o, busy_o} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctl got=%b want=0000",
                  {mem_req_o, refill_we_o, refill_done_o, busy_o});
      end
      checks++;
      if (mem_addr_o !== 32'h0 || refill_idx_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_addr got=%h/%0d want=0/0",
                  mem_addr_o, refill_idx_o);
      end
      next_cycle();
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || en !== 1'b1) begin
         errors++;
         $display("FAIL reset_release busy=%b en=%b want 0 1", busy_o, en);
      end
      next_cycle();
   endtask

   task automatic test_hit_run();
      idle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (en !== 1'b1 || flush_d_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL hit_run cyc=%0d en/flush/req=%b%b%b want 100",
                     i, en, flush_d_o, mem_req_o);
         end
         next_cycle();
      end
      stall_i = 1'b1;
      @(negedge clk);
      checks++;
      if (en !== 1'b0 || flush_d_o !== 1'b0) begin
         errors++;
         $display("FAIL hit_stall en/flush=%b%b want 00", en, flush_d_o);
      end
      next_cycle();
      idle();
   endtask

   task automatic test_miss_refill();
      int busy_n;
      int done_n;
      busy_n = 0;
      done_n = 0;
      idle();
      PCF = 32'h0000_0104;
      icache_hit_i = 1'b0;
      @(negedge clk);
      checks++;
      if (flush_d_o !== 1'b1 || en !== 1'b0) begin
         errors++;
         $display("FAIL miss_bubble flush/en=%b%b want 10", flush_d_o, en);
      end
      next_cycle();
      icache_hit_i = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         mem_gnt_i    = (k == 3);
         mem_rvalid_i = (k == 2) || (k >= 4 && k <= 7);
         @(negedge clk);
         if (busy_o === 1'b1) busy_n++;
         if (refill_done_o === 1'b1) done_n++;
         if (k == 1 || k == 3) begin
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
               errors++;
               $display("FAIL miss_req k=%0d req=%b addr=%h want 1 100",
                        k, mem_req_o, mem_addr_o);
            end
         end
         if (k == 2) begin
            checks++;
            if (refill_we_o !== 1'b0) begin
               errors++;
               $display("FAIL rvalid_in_req we=%b want 0", refill_we_o);
            end
         end
         if (k >= 4 && k <= 7) begin
            checks++;
            if (refill_we_o !== 1'b1 || refill_idx_o !== 2'(k - 4)) begin
               errors++;
               $display("FAIL miss_beat k=%0d we=%b idx=%0d want 1 %0d",
                        k, refill_we_o, refill_idx_o, k - 4);
            end
         end
         if (k == 8) begin
            checks++;
            if (refill_done_o !== 1'b1) begin
               errors++;
               $display("FAIL miss_done got=%b want 1", refill_done_o);
            end
         end
         next_cycle();
      end
      checks++;
      if (busy_n != 8) begin
         errors++;
         $display("FAIL miss_busy_len got=%0d want 8", busy_n);
      end
      checks++;
      if (done_n != 1) begin
         errors++;
         $display("FAIL miss_done_cnt got=%0d want 1", done_n);
      end
      idle();
   endtask

   task automatic test_redirect_fill();
      idle();
      PCF = 32'h0000_0208;
      icache_hit_i = 1'b0;
      next_cycle();
      icache_hit_i = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         mem_gnt_i    = (k == 1);
         mem_rvalid_i = (k >= 2 && k <= 5);
         PCSrcE       = (k == 3) ? 2'b01 : 2'b00;
         @(negedge clk);
         if (k == 1) begin
            checks++;
            if (mem_addr_o !== 32'h200) begin
               errors++;
               $display("FAIL redir_addr got=%h want 200", mem_addr_o);
            end
         end
         if (k == 3) begin
            checks++;
            if (en !== 1'b1 || flush_d_o !== 1'b1 || busy_o !== 1'b1) begin
               errors++;
               $display("FAIL redir_fill en/flush/busy=%b%b%b want 111",
                        en, flush_d_o, busy_o);
            end
         end
         if (k >= 2 && k <= 5) begin
            checks++;
            if (refill_we_o !== 1'b1 || refill_idx_o !== 2'(k - 2)) begin
               errors++;
               $display("FAIL redir_beat k=%0d we=%b idx=%0d want 1 %0d",
                        k, refill_we_o, refill_idx_o, k - 2);
            end
         end
         if (k == 6) begin
            checks++;
            if (refill_done_o !== 1'b1) begin
               errors++;
               $display("FAIL redir_done got=%b want 1", refill_done_o);
            end
         end
         if (k == 7) begin
            checks++;
            if (busy_o !== 1'b0 || en !== 1'b1) begin
               errors++;
               $display("FAIL redir_back busy=%b en=%b want 0 1", busy_o, en);
            end
         end
         next_cycle();
      end
      idle();
   endtask

   task automatic test_miss_redirect();
      idle();
      PCF = 32'h0000_0400;
      icache_hit_i  = 1'b0;
      pc_redirect_i = 1'b1;
      @(negedge clk);
      checks++;
      if (en !== 1'b1 || flush_d_o !== 1'b1) begin
         errors++;
         $display("FAIL miss_redir en/flush=%b%b want 11", en, flush_d_o);
      end
      next_cycle();
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_redir_noreq cyc=%0d req=%b busy=%b want 0 0",
                     i, mem_req_o, busy_o);
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid();
      int done_n;
      int we_n;
      done_n = 0;
      we_n   = 0;
      idle();
      PCF = 32'h0000_0300;
      icache_hit_i = 1'b0;
      next_cycle();
      icache_hit_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         mem_gnt_i    = (k == 1);
         mem_rvalid_i = (k >= 2);
         next_cycle();
      end
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = 1'b0;
      stall_i      = 1'b1;
      icache_hit_i = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({en, flush_d_o, mem_req_o, refill_we_o, refill_done_o, busy_o}
          !== 6'b0) begin
         errors++;
         $display("FAIL rst_mid_ctl got=%b want 000000",
                  {en, flush_d_o, mem_req_o, refill_we_o,
                   refill_done_o, busy_o});
      end
      checks++;
      if (mem_addr_o !== 32'h0 || refill_idx_o !== 2'd0) begin
         errors++;
         $display("FAIL rst_mid_addr got=%h/%0d want 0/0",
                  mem_addr_o, refill_idx_o);
      end
      next_cycle();
      next_cycle();
      rst = 1'b1;
      idle();
      mem_rvalid_i = 1'b1;
      mem_gnt_i    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (refill_done_o === 1'b1) done_n++;
         if (refill_we_o === 1'b1) we_n++;
         next_cycle();
      end
      checks++;
      if (done_n != 0 || we_n != 0) begin
         errors++;
         $display("FAIL rst_mid_drop done=%0d we=%0d want 0 0", done_n, we_n);
      end
      idle();
   endtask

`ifdef FETCH_CTRL_PERF_EN
   task automatic test_perf();
      idle();
      rst = 1'b0;
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (miss_cnt_o !== 32'd0 || stall_cnt_o !== 32'd0) begin
         errors++;
         $display("FAIL perf_clear miss=%0d stall=%0d want 0 0",
                  miss_cnt_o, stall_cnt_o);
      end
      next_cycle();
      for (int m = 0; m < 3; m++) begin
         PCF = 32'h0000_1000 + 32'(m * 16);
         icache_hit_i = 1'b0;
         next_cycle();
         icache_hit_i = 1'b1;
         for (int k = 1; k <= 7; k++) begin
            mem_gnt_i    = (k == 2);
            mem_rvalid_i = (k >= 3 && k <= 6);
            next_cycle();
         end
         idle();
      end
      @(negedge clk);
      checks++;
      if (miss_cnt_o !== 32'd3 || stall_cnt_o !== 32'd21) begin
         errors++;
         $display("FAIL perf_cnt miss=%0d stall=%0d want 3 21",
                  miss_cnt_o, stall_cnt_o);
      end
      next_cycle();
   endtask
`endif

   initial begin
      test_reset();
      test_hit_run();
      test_miss_refill();
      test_redirect_fill();
      test_miss_redirect();
      test_reset_mid();
`ifdef FETCH_CTRL_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
